// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared types and constants for the instruction image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LEN_LO   = 3'd1,
      S_LEN_HI   = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_LOAD     = 3'd4,
      S_FINISH   = 3'd5
   } state_t;

   // Default image start marker
   localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

   // States in which the loader owns (or is requesting) instruction memory
   function automatic logic is_load_mode(input state_t s);
      return (s == S_WAIT_ACK) || (s == S_LOAD) || (s == S_FINISH);
   endfunction

   // States in which the inter-byte gap is supervised
   function automatic logic is_timed(input state_t s);
      return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_WAIT_ACK) || (s == S_LOAD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rx_timeout.sv
// ============================================================================
// Module      : rx_timeout
// Description : Inter-byte gap supervisor. Counts enabled cycles since the
//               last clear and flags expiry once TIMEOUT_CYCLES is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int                 C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYCLES);

   logic [C_CNT_W-1:0] r_count;

   // Gap counter: reloads on clear, saturates at the limit
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != C_LIMIT)) begin
         r_count <= r_count + C_CNT_W'(1);
      end
   end

   assign o_expired = (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module      : instr_loader
// Description : Receives an instruction image over a UART byte stream
//               (sync byte, 16-bit word count, little-endian words) and
//               writes it into instruction memory through the load bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int         INSTR_MEM_SIZE = 256,
   parameter logic [7:0] SYNC_BYTE      = C_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   input  logic        i_mem_wait,
   output logic [31:0] o_ld_instr_in,
   output logic [31:0] o_ld_instr_addr,
   output logic        o_ld_instr_wren,
   output logic        o_ld_instr_active,
   output logic        o_done,
   output logic        o_error
);

   localparam logic [31:0] C_MAX_LEN = 32'(INSTR_MEM_SIZE);

   state_t      r_state,     w_state_n;
   logic [15:0] r_len,       w_len_n;
   logic [1:0]  r_byte_idx,  w_byte_idx_n;
   logic [23:0] r_shift,     w_shift_n;     // three most recent bytes of the word in progress
   logic        r_pend,      w_pend_n;
   logic [31:0] r_pend_word, w_pend_word_n; // completed word awaiting its write slot
   logic [31:0] r_addr,      w_addr_n;
   logic [15:0] r_wr_cnt,    w_wr_cnt_n;
   logic [15:0] r_rx_words,  w_rx_words_n;  // words assembled so far; caps capture at N
   logic [31:0] r_instr_in,  w_instr_in_n;
   logic [31:0] r_instr_addr, w_instr_addr_n;
   logic        r_wren,      w_wren_n;
   logic        r_active,    w_active_n;
   logic        r_done,      w_done_n;
   logic        r_error,     w_error_n;

   logic [15:0] w_len_full;
   logic        w_expired;
   logic        w_tmo_clear;
   logic        w_tmo_en;

   assign w_len_full  = {i_rx_data, r_len[7:0]};
   assign w_tmo_en    = is_timed(r_state);
   assign w_tmo_clear = i_rx_valid || !w_tmo_en;

   rx_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_tmo_clear),
      .i_enable  (w_tmo_en),
      .o_expired (w_expired)
   );

   // State and datapath register bank; every output is taken from here
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_byte_idx   <= '0;
         r_shift      <= '0;
         r_pend       <= 1'b0;
         r_pend_word  <= '0;
         r_addr       <= '0;
         r_wr_cnt     <= '0;
         r_rx_words   <= '0;
         r_instr_in   <= '0;
         r_instr_addr <= '0;
         r_wren       <= 1'b0;
         r_active     <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_len        <= w_len_n;
         r_byte_idx   <= w_byte_idx_n;
         r_shift      <= w_shift_n;
         r_pend       <= w_pend_n;
         r_pend_word  <= w_pend_word_n;
         r_addr       <= w_addr_n;
         r_wr_cnt     <= w_wr_cnt_n;
         r_rx_words   <= w_rx_words_n;
         r_instr_in   <= w_instr_in_n;
         r_instr_addr <= w_instr_addr_n;
         r_wren       <= w_wren_n;
         r_active     <= w_active_n;
         r_done       <= w_done_n;
         r_error      <= w_error_n;
      end
   end

   // Next-state, byte capture and write-slot decisions
   always_comb begin
      w_state_n      = r_state;
      w_len_n        = r_len;
      w_byte_idx_n   = r_byte_idx;
      w_shift_n      = r_shift;
      w_pend_n       = r_pend;
      w_pend_word_n  = r_pend_word;
      w_addr_n       = r_addr;
      w_wr_cnt_n     = r_wr_cnt;
      w_rx_words_n   = r_rx_words;
      w_instr_in_n   = '0;
      w_instr_addr_n = '0;
      w_wren_n       = 1'b0;
      w_done_n       = 1'b0;
      w_error_n      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
               w_state_n = S_LEN_LO;
            end
         end

         S_LEN_LO: begin
            if (w_expired) begin
               w_error_n = 1'b1;
               w_state_n = S_IDLE;
            end else if (i_rx_valid) begin
               w_len_n   = {8'h00, i_rx_data};
               w_state_n = S_LEN_HI;
            end
         end

         S_LEN_HI: begin
            if (w_expired) begin
               w_error_n = 1'b1;
               w_state_n = S_IDLE;
            end else if (i_rx_valid) begin
               if ((w_len_full == 16'd0) || ({16'd0, w_len_full} > C_MAX_LEN)) begin
                  w_error_n = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  w_len_n      = w_len_full;
                  w_byte_idx_n = '0;
                  w_pend_n     = 1'b0;
                  w_addr_n     = '0;
                  w_wr_cnt_n   = '0;
                  w_rx_words_n = '0;
                  w_state_n    = S_WAIT_ACK;
               end
            end
         end

         S_WAIT_ACK, S_LOAD: begin
            if (w_expired) begin
               w_error_n = 1'b1;
               w_pend_n  = 1'b0;
               w_state_n = S_IDLE;
            end else begin
               // Write slot: only once the memory is ours
               if ((r_state == S_LOAD) && r_pend) begin
                  w_wren_n       = 1'b1;
                  w_instr_in_n   = r_pend_word;
                  w_instr_addr_n = r_addr;
                  w_addr_n       = r_addr + 32'd1;
                  w_wr_cnt_n     = r_wr_cnt + 16'd1;
                  w_pend_n       = 1'b0;
                  if ((r_wr_cnt + 16'd1) == r_len) begin
                     w_state_n = S_FINISH;
                  end
               end
               // Byte capture runs independently of the write slot; a
               // completed word overrides the pending flag cleared above.
               // A second word completing before the grant overwrites the
               // first; the mapper is expected to grant within a word time.
               if (i_rx_valid && (r_rx_words < r_len)) begin
                  w_shift_n    = {i_rx_data, r_shift[23:8]};
                  w_byte_idx_n = r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     w_pend_word_n = {i_rx_data, r_shift};
                     w_pend_n      = 1'b1;
                     w_rx_words_n  = r_rx_words + 16'd1;
                  end
               end
               if ((r_state == S_WAIT_ACK) && i_mem_wait) begin
                  w_state_n = S_LOAD;
               end
            end
         end

         S_FINISH: begin
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
         end

         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      w_active_n = is_load_mode(w_state_n);
   end

   assign o_ld_instr_in     = r_instr_in;
   assign o_ld_instr_addr   = r_instr_addr;
   assign o_ld_instr_wren   = r_wren;
   assign o_ld_instr_active = r_active;
   assign o_done            = r_done;
   assign o_error           = r_error;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader: table vectors, random
//               images against an image-format reference model, and
//               hand-written grant-delay, timeout and mid-load reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

   localparam int         C_MEM  = 256;
   localparam int         C_TMO  = 100;
   localparam logic [7:0] C_SYNC = 8'hA5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        mem_wait = 1'b0;
   logic [31:0] ld_instr_in;
   logic [31:0] ld_instr_addr;
   logic        ld_instr_wren;
   logic        ld_instr_active;
   logic        done;
   logic        error;

   instr_loader #(
      .INSTR_MEM_SIZE (C_MEM),
      .SYNC_BYTE      (C_SYNC),
      .TIMEOUT_CYCLES (C_TMO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .i_rx_data         (rx_data),
      .i_rx_valid        (rx_valid),
      .i_mem_wait        (mem_wait),
      .o_ld_instr_in     (ld_instr_in),
      .o_ld_instr_addr   (ld_instr_addr),
      .o_ld_instr_wren   (ld_instr_wren),
      .o_ld_instr_active (ld_instr_active),
      .o_done            (done),
      .o_error           (error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation (cumulative; tests take baselines)
   logic [63:0] wq[$];
   int tot_done = 0, tot_err = 0, tot_act = 0, tot_zero_viol = 0;
   int last_err_cyc = 0;
   int last_byte_cyc = 0;
   int b_wq, b_done, b_err, b_act, b_zero;

   always @(negedge clk) begin
      if (ld_instr_wren) wq.push_back({ld_instr_addr, ld_instr_in});
      if (done) tot_done++;
      if (error) begin tot_err++; last_err_cyc = cyc; end
      if (ld_instr_active) tot_act++;
      if (!ld_instr_wren && (ld_instr_in != 32'd0 || ld_instr_addr != 32'd0)) tot_zero_viol++;
   end

   // Memory mapper stand-in: grants mw_delay cycles after active rises
   int   mw_delay = 1;
   logic mw_hold_low = 1'b0;
   int   act_cnt = 0;
   always @(negedge clk) begin
      if (!ld_instr_active) begin
         act_cnt  = 0;
         mem_wait = 1'b0;
      end else begin
         act_cnt++;
         mem_wait = (act_cnt > mw_delay) && !mw_hold_low;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data       = b;
      rx_valid      = 1'b1;
      last_byte_cyc = cyc + 1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (gap) @(negedge clk);
   endtask

   logic [7:0] stim[$];

   task automatic send_stim(input int gmin, input int gmax);
      foreach (stim[k]) send_byte(stim[k], $urandom_range(gmax, gmin));
   endtask

   task automatic mark();
      b_wq = wq.size(); b_done = tot_done; b_err = tot_err;
      b_act = tot_act; b_zero = tot_zero_viol;
   endtask

   task automatic wait_outcome(input int bound);
      int k = 0;
      while ((tot_done + tot_err == b_done + b_err) && k < bound) begin
         @(negedge clk);
         k++;
      end
      repeat (8) @(negedge clk);
   endtask

   // Reference model: image format rules applied directly to the byte list
   int          exp_done, exp_err;
   logic [31:0] exp_words[$];

   task automatic model();
      int i = 0;
      int n;
      exp_words.delete();
      exp_done = 0;
      exp_err  = 0;
      while (i < stim.size() && stim[i] != C_SYNC) i++;
      if (i + 2 >= stim.size()) return;
      n = int'(stim[i+1]) + 256 * int'(stim[i+2]);
      if (n == 0 || n > C_MEM) begin exp_err = 1; return; end
      if (stim.size() < i + 3 + 4 * n) begin exp_err = 1; return; end
      for (int w = 0; w < n; w++) begin
         int p = i + 3 + 4 * w;
         exp_words.push_back({stim[p+3], stim[p+2], stim[p+1], stim[p]});
      end
      exp_done = 1;
   endtask

   task automatic compare_obs(input string tag);
      int nw = wq.size() - b_wq;
      chk({tag, "_done"}, tot_done - b_done, exp_done);
      chk({tag, "_error"}, tot_err - b_err, exp_err);
      chk({tag, "_nwrites"}, nw, exp_words.size());
      for (int k = 0; k < nw && k < exp_words.size(); k++) begin
         chk({tag, "_addr"}, wq[b_wq+k][63:32], k);
         chk({tag, "_data"}, wq[b_wq+k][31:0], exp_words[k]);
      end
      chk({tag, "_idle_zero"}, tot_zero_viol - b_zero, 0);
      if (exp_err != 0) chk({tag, "_active_seen"}, tot_act - b_act, 0);
      chk({tag, "_active_end"}, ld_instr_active, 0);
   endtask

   typedef struct {
      logic [127:0] bytes;
      int           n;
      int           mwd;
      int           e_err;
      int           e_done;
      int           e_nw;
      logic [31:0]  e_w0;
      logic [31:0]  e_w1;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [127:0] bv;
      int n;

      tbl[0] = '{128'hA5_02_00_13_00_00_00_93_00_10_00, 11, 1, 0, 1, 2, 32'h0000_0013, 32'h0010_0093};
      tbl[1] = '{128'hA5_00_00, 3, 1, 1, 0, 0, 32'h0, 32'h0};
      tbl[2] = '{128'hA5_01_01, 3, 1, 1, 0, 0, 32'h0, 32'h0};
      tbl[3] = '{128'h00_FF_A5_01_00_44_33_22_11, 9, 0, 0, 1, 1, 32'h1122_3344, 32'h0};
      tbl[4] = '{128'hA5_01_00_EF_BE_AD_DE_77_66, 9, 3, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wren", ld_instr_wren, 0);
      chk("rst_active", ld_instr_active, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_instr", ld_instr_in, 0);
      chk("rst_addr", ld_instr_addr, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Table vectors
      foreach (tbl[t]) begin
         bv = tbl[t].bytes;
         n  = tbl[t].n;
         stim.delete();
         for (int k = 0; k < n; k++) stim.push_back(bv[8*(n-1-k) +: 8]);
         mw_delay = tbl[t].mwd;
         exp_done = tbl[t].e_done;
         exp_err  = tbl[t].e_err;
         exp_words.delete();
         if (tbl[t].e_nw > 0) exp_words.push_back(tbl[t].e_w0);
         if (tbl[t].e_nw > 1) exp_words.push_back(tbl[t].e_w1);
         mark();
         send_stim(1, 1);
         wait_outcome(300);
         compare_obs($sformatf("tbl%0d", t));
      end

      // Randomized images against the reference model
      for (int r = 0; r < 12; r++) begin
         int nw;
         stim.delete();
         for (int g = $urandom_range(2, 0); g > 0; g--) begin
            logic [7:0] gb = 8'($urandom_range(255, 0));
            stim.push_back(gb == C_SYNC ? 8'h5A : gb);
         end
         if (r == 5)                        nw = C_MEM;
         else if ($urandom_range(5, 0) == 0) nw = $urandom_range(1, 0) ? 0 : $urandom_range(65535, C_MEM + 1);
         else                               nw = $urandom_range(6, 1);
         stim.push_back(C_SYNC);
         stim.push_back(8'(nw));
         stim.push_back(8'(nw >> 8));
         if (nw >= 1 && nw <= C_MEM)
            for (int k = 0; k < 4 * nw; k++) stim.push_back(8'($urandom_range(255, 0)));
         mw_delay = $urandom_range(3, 0);
         model();
         mark();
         send_stim(0, (r == 5) ? 1 : 4);
         wait_outcome(300);
         compare_obs($sformatf("rnd%0d", r));
      end

      // Grant withheld for 50 cycles while a full word arrives
      stim.delete();
      stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      mw_delay = 1;
      mw_hold_low = 1'b1;
      mark();
      send_stim(1, 1);
      repeat (50) @(negedge clk);
      chk("hold_nwrites", wq.size() - b_wq, 0);
      chk("hold_active", ld_instr_active, 1);
      mw_hold_low = 1'b0;
      model();
      wait_outcome(100);
      compare_obs("hold");

      // Stream stalls after 2 of 4 data bytes
      stim.delete();
      stim = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02};
      mark();
      send_stim(1, 1);
      wait_outcome(300);
      chk("tmo_error", tot_err - b_err, 1);
      chk("tmo_done", tot_done - b_done, 0);
      chk("tmo_nwrites", wq.size() - b_wq, 0);
      chk("tmo_active_end", ld_instr_active, 0);
      chk("tmo_delay_window", ((last_err_cyc - last_byte_cyc) >= C_TMO) &&
                              ((last_err_cyc - last_byte_cyc) <= C_TMO + 2), 1);

      // Reset in LOAD after one write, then a fresh image
      stim.delete();
      stim = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      mark();
      send_stim(1, 1);
      for (int k = 0; k < 20 && wq.size() == b_wq; k++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_active", ld_instr_active, 0);
      stim.delete();
      stim = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89};
      send_stim(1, 1);
      wait_outcome(300);
      chk("mid_rst_nwrites", wq.size() - b_wq, 2);
      if (wq.size() - b_wq >= 2) begin
         chk("mid_rst_w0_data", wq[b_wq][31:0], 32'h1234_5678);
         chk("mid_rst_w1_addr", wq[b_wq+1][63:32], 32'd0);
         chk("mid_rst_w1_data", wq[b_wq+1][31:0], 32'h89AB_CDEF);
      end
      chk("mid_rst_done", tot_done - b_done, 1);
      chk("mid_rst_error", tot_err - b_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter INSTR_MEM_SIZE, default 256, the instruction memory depth in words.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, the image start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum allowed gap between bytes during a load.
REQ-004 SHALL have port clk input 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset input 1, a synchronous active-high reset.
REQ-006 SHALL have port i_rx_data input 8, a byte from the upstream UART receiver.
REQ-007 SHALL have port i_rx_valid input 1, a one-cycle strobe that qualifies i_rx_data.
REQ-008 SHALL have port i_mem_wait input 1, the memory mapper's acknowledgement that the load bus owns instruction memory.
REQ-009 SHALL have port o_ld_instr_in output 32, the assembled instruction word.
REQ-010 SHALL have port o_ld_instr_addr output 32, the word address of o_ld_instr_in.
REQ-011 SHALL have port o_ld_instr_wren output 1, a one-cycle write strobe.
REQ-012 SHALL have port o_ld_instr_active output 1, which requests and holds load mode.
REQ-013 SHALL have port o_done output 1, a one-cycle pulse on successful completion.
REQ-014 SHALL have port o_error output 1, a one-cycle pulse on a rejected header or a timeout.

Function
REQ-015 SHALL accept the image format: SYNC_BYTE, then word count N as 16 bits (LSB first), then N words of 4 bytes each (LSB first).
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, WAIT_ACK, LOAD, FINISH.
- IDLE: ignores every byte except SYNC_BYTE, which moves the FSM to LEN_LO.
- LEN_LO -> LEN_HI -> WAIT_ACK: each transition occurs on one valid byte.
REQ-017 SHALL, in LEN_HI, pulse o_error and return to IDLE without asserting active when N==0 or N>INSTR_MEM_SIZE.
REQ-018 SHALL hold o_ld_instr_active high in WAIT_ACK, LOAD and FINISH, and low in all other states.
REQ-019 SHALL leave WAIT_ACK for LOAD on the first cycle in which i_mem_wait==1.
REQ-020 SHALL capture bytes in both WAIT_ACK and LOAD, using a 2-bit byte index that wraps 3->0 on each completed word and a one-bit word-pending flag.
REQ-021 SHALL assert o_ld_instr_wren only in LOAD, only while a word is pending, for exactly one cycle per word, with data and address stable in that same cycle.
REQ-022 SHALL start o_ld_instr_addr at 0 for each image and increment it by 1 after each write.
REQ-023 SHALL enter FINISH in the cycle after the Nth write, and SHALL ignore any bytes beyond N words.
REQ-024 SHALL, in FINISH, drop active on the following cycle, pulse o_done, and return to IDLE.
REQ-025 SHALL, on a valid byte arriving in the same cycle as a pending write, still capture that byte; the pending word register SHALL be separate from the byte shift register.
REQ-026 SHALL reload the timeout counter on every valid byte from LEN_LO through LOAD.
REQ-027 SHALL, if the timeout counter reaches TIMEOUT_CYCLES before the image completes, pulse o_error, drop active and return to IDLE with no further writes.
REQ-028 SHALL drive o_ld_instr_in and o_ld_instr_addr to 0 whenever wren==0.

Reset
REQ-029 SHALL, on reset, set the state to IDLE and set every output, the counters, the byte index, the pending flag and N to 0.
REQ-030 SHALL, when reset is asserted mid-load, drop active on the next edge and discard the partial image with no o_done or o_error pulse.

Structure
REQ-031 SHALL take the state encodings and the SYNC_BYTE default from the shared project package.
REQ-032 SHALL implement the timeout counter as the sub-module rx_timeout (inputs: clear, enable; output: expired).
REQ-033 SHALL keep all outputs registered.

Verification
REQ-034 SHALL cover: bytes A5 02 00 13 00 00 00 93 00 10 00 with i_mem_wait rising 1 cycle after active -> writes 0x00000013 @0 and 0x00100093 @1, one cycle each, then o_done and active low.
REQ-035 SHALL cover: A5 00 00 -> o_error pulse, active never high, no wren.
REQ-036 SHALL cover: A5 01 01 (N=257) -> o_error pulse, no active.
REQ-037 SHALL cover: i_mem_wait held low 50 cycles while 4 data bytes arrive -> no wren until i_mem_wait=1, then exactly one write @0.
REQ-038 SHALL cover: TIMEOUT_CYCLES=100 with the stream stopped after 2 of 4 data bytes -> o_error at cycle 100, active low, no wren.
REQ-039 SHALL cover: reset asserted in LOAD after 1 write, then a fresh image -> the first write of the new image goes to address 0.
